// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the in-order pipeline: arbitrates hazard sources
// into stall, bubble, flush and redirect controls and counts fetch stalls.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   icache_miss_i       fetch has no valid instruction this cycle
//   load_use_i          decode depends on the load currently in exec
//   dcache_miss_i       memory stage waiting (level)
//   branch_taken_i      exec resolved a taken branch, target in branch_target_i
//   exception_i         exec raised an exception
//   clear_cnt_i         synchronous clear of stall_cnt_o
//   stall_*_o/bubble_*_o latch controls; flush_o clears both latches
//   redirect_o/_pc_o    PC redirect request and target (0 when idle)
//   stall_cnt_o         saturating count of cycles with stall_fetch_o=1
module pipe_hazard_ctrl #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  EXC_VEC    = 'h2000,
    parameter int               FLUSH_LEN  = 1,
    parameter int               LU_BUBBLES = 1,
    parameter int               CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             icache_miss_i,
    input  logic             load_use_i,
    input  logic             dcache_miss_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic             exception_i,
    input  logic             clear_cnt_i,
    output logic             stall_fetch_o,
    output logic             bubble_dec_o,
    output logic             stall_dec_o,
    output logic             bubble_exec_o,
    output logic             stall_exec_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MAXN = (FLUSH_LEN > LU_BUBBLES) ? FLUSH_LEN : LU_BUBBLES;
    localparam int CW   = (MAXN > 2) ? $clog2(MAXN) : 1;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_STALL,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    logic             sf, bd, sd, be, se, fl, rd;
    logic [XLEN-1:0]  rpc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sf      = 1'b0;
        bd      = 1'b0;
        sd      = 1'b0;
        be      = 1'b0;
        se      = 1'b0;
        fl      = 1'b0;
        rd      = 1'b0;
        rpc     = '0;
        unique case (state_q)
            RUN, LU_STALL: begin
                if (exception_i || branch_taken_i) begin
                    fl  = 1'b1;
                    rd  = 1'b1;
                    rpc = exception_i ? EXC_VEC : branch_target_i;
                    if (FLUSH_LEN > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CW'(FLUSH_LEN - 2);
                    end else begin
                        state_d = RUN;
                    end
                end else if (dcache_miss_i) begin
                    // Pending load-use bubbles are dropped: the miss
                    // already holds decode until exec moves again.
                    sf      = 1'b1;
                    sd      = 1'b1;
                    se      = 1'b1;
                    state_d = MEM_STALL;
                end else if (state_q == LU_STALL) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    be = 1'b1;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CW'(1);
                end else if (load_use_i) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    be = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_d = LU_STALL;
                        cnt_d   = CW'(LU_BUBBLES - 2);
                    end
                end else if (icache_miss_i) begin
                    sf = 1'b1;
                    bd = 1'b1;
                end
            end
            MEM_STALL: begin
                // Exec is frozen, so redirects cannot be resolved here.
                sf = dcache_miss_i;
                sd = dcache_miss_i;
                se = dcache_miss_i;
                if (!dcache_miss_i) state_d = RUN;
            end
            FLUSH: begin
                fl = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        scnt_d = scnt_q;
        if (clear_cnt_i)
            scnt_d = '0;
        else if (stall_fetch_o && scnt_q != '1)
            scnt_d = scnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
        end
    end

    // Outputs are gated so that reset overrides any input pattern.
    assign stall_fetch_o = sf & ~rst_i;
    assign bubble_dec_o  = bd & ~rst_i;
    assign stall_dec_o   = sd & ~rst_i;
    assign bubble_exec_o = be & ~rst_i;
    assign stall_exec_o  = se & ~rst_i;
    assign flush_o       = fl & ~rst_i;
    assign redirect_o    = rd & ~rst_i;
    assign redirect_pc_o = rst_i ? '0 : rpc;
    assign stall_cnt_o   = scnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances with different
// FLUSH_LEN / LU_BUBBLES / CNT_W share one stimulus stream.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic, lu, dm, bt, ex, cl;
    logic [31:0] tgt;

    logic        sf0, bd0, sd0, be0, se0, fl0, rd0;
    logic [31:0] pc0, cnt0;
    logic        sf1, bd1, sd1, be1, se1, fl1, rd1;
    logic [31:0] pc1;
    logic [3:0]  cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    // {stall_fetch, bubble_dec, stall_dec, bubble_exec, stall_exec, flush, redirect}
    localparam logic [6:0] O_NONE = 7'h00;
    localparam logic [6:0] O_LU   = 7'h58;
    localparam logic [6:0] O_MEM  = 7'h54;
    localparam logic [6:0] O_IC   = 7'h60;
    localparam logic [6:0] O_FLRD = 7'h03;
    localparam logic [6:0] O_FL   = 7'h02;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_LEN (2),
        .LU_BUBBLES(2),
        .CNT_W     (32)
    ) u0 (
        .clk_i          (clk),
        .rst_i          (rst),
        .icache_miss_i  (ic),
        .load_use_i     (lu),
        .dcache_miss_i  (dm),
        .branch_taken_i (bt),
        .branch_target_i(tgt),
        .exception_i    (ex),
        .clear_cnt_i    (cl),
        .stall_fetch_o  (sf0),
        .bubble_dec_o   (bd0),
        .stall_dec_o    (sd0),
        .bubble_exec_o  (be0),
        .stall_exec_o   (se0),
        .flush_o        (fl0),
        .redirect_o     (rd0),
        .redirect_pc_o  (pc0),
        .stall_cnt_o    (cnt0)
    );

    pipe_hazard_ctrl #(
        .FLUSH_LEN (1),
        .LU_BUBBLES(3),
        .CNT_W     (4)
    ) u1 (
        .clk_i          (clk),
        .rst_i          (rst),
        .icache_miss_i  (ic),
        .load_use_i     (lu),
        .dcache_miss_i  (dm),
        .branch_taken_i (bt),
        .branch_target_i(tgt),
        .exception_i    (ex),
        .clear_cnt_i    (cl),
        .stall_fetch_o  (sf1),
        .bubble_dec_o   (bd1),
        .stall_dec_o    (sd1),
        .bubble_exec_o  (be1),
        .stall_exec_o   (se1),
        .flush_o        (fl1),
        .redirect_o     (rd1),
        .redirect_pc_o  (pc1),
        .stall_cnt_o    (cnt1)
    );

    wire [6:0] o0 = {sf0, bd0, sd0, be0, se0, fl0, rd0};
    wire [6:0] o1 = {sf1, bd1, sd1, be1, se1, fl1, rd1};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs on the falling edge; outputs are checked 1 ns later.
    task automatic drive(input logic i_ic, input logic i_lu, input logic i_dm,
                         input logic i_bt, input logic [31:0] i_tgt,
                         input logic i_ex, input logic i_cl);
        @(negedge clk);
        ic  = i_ic;
        lu  = i_lu;
        dm  = i_dm;
        bt  = i_bt;
        tgt = i_tgt;
        ex  = i_ex;
        cl  = i_cl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        // 1: reset with every input high
        rst = 1'b1;
        ic = 1; lu = 1; dm = 1; bt = 1; ex = 1; cl = 1; tgt = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", {25'h0, o0}, 32'h0);
        check("rst_out1", {25'h0, o1}, 32'h0);
        check("rst_pc0", pc0, 32'h0);
        check("rst_cnt0", cnt0, 32'h0);
        check("rst_cnt1", {28'h0, cnt1}, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        rst = 1'b0;
        #1;
        check("run_out0", {25'h0, o0}, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        check("ic_out0", {25'h0, o0}, {25'h0, O_IC});
        idle(2);

        // 2: single load-use, two bubbles on u0
        drive(0, 0, 0, 0, 32'h0, 0, 1);
        drive(0, 1, 0, 0, 32'h0, 0, 0);
        check("lu_c1", {25'h0, o0}, {25'h0, O_LU});
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("lu_c2", {25'h0, o0}, {25'h0, O_LU});
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("lu_c3", {25'h0, o0}, 32'h0);
        check("lu_cnt", cnt0, 32'd2);
        idle(4);

        // 3: five-cycle dcache miss with a branch pulse in the middle
        for (int c = 1; c <= 5; c++) begin
            drive(0, 0, 1, (c == 3), 32'h400, 0, 0);
            check($sformatf("mem_c%0d", c), {25'h0, o0}, {25'h0, O_MEM});
            check($sformatf("mem_pc%0d", c), pc0, 32'h0);
        end
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("mem_c6", {25'h0, o0}, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 0, 0);
        check("mem_run_lu", {25'h0, o0}, {25'h0, O_LU});
        idle(5);

        // 4: branch + exception together; exception wins, 2-cycle flush
        drive(0, 0, 0, 1, 32'h100, 1, 0);
        check("exc_c1", {25'h0, o0}, {25'h0, O_FLRD});
        check("exc_pc", pc0, 32'h2000);
        check("exc_pc_u1", pc1, 32'h2000);
        drive(0, 1, 0, 0, 32'h0, 0, 0);
        check("exc_c2", {25'h0, o0}, {25'h0, O_FL});
        check("exc_c2_pc", pc0, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("exc_c3", {25'h0, o0}, 32'h0);
        drive(0, 0, 0, 1, 32'h100, 0, 0);
        check("br_c1", {25'h0, o0}, {25'h0, O_FLRD});
        check("br_pc", pc0, 32'h100);
        idle(5);

        // 5: saturation of the 4-bit counter, then clear during a stall
        drive(0, 0, 0, 0, 32'h0, 0, 1);
        for (int c = 0; c < 20; c++) begin
            drive(1, 0, 0, 0, 32'h0, 0, 0);
            if (c == 15) check("sat_15", {28'h0, cnt1}, 32'hF);
        end
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("sat_20", {28'h0, cnt1}, 32'hF);
        check("cnt32_20", cnt0, 32'd20);
        drive(1, 0, 0, 0, 32'h0, 0, 1);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("clr_cnt1", {28'h0, cnt1}, 32'h0);
        check("clr_cnt0", cnt0, 32'h0);
        idle(2);

        // 6: dcache miss in the 2nd of three load-use bubbles on u1
        drive(0, 1, 0, 0, 32'h0, 0, 0);
        check("lum_c1", {25'h0, o1}, {25'h0, O_LU});
        drive(0, 0, 1, 0, 32'h0, 0, 0);
        check("lum_c2", {25'h0, o1}, {25'h0, O_MEM});
        drive(0, 0, 1, 0, 32'h0, 0, 0);
        check("lum_c3", {25'h0, o1}, {25'h0, O_MEM});
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("lum_c4", {25'h0, o1}, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        check("lum_c5", {25'h0, o1}, 32'h0);

        // Reset in the middle of a flush drops it at once
        drive(0, 0, 0, 1, 32'h80, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_mid", {25'h0, o0}, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_rel", {25'h0, o0}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
